// File: rtl/i2c_target_bank.sv
// I2C target exposing a byte register bank: address, pointer byte, then
// auto-incrementing data bytes; a host port writes/reads the same registers.
module i2c_target_bank #(
  parameter logic [6:0]  ADDR        = 7'h34,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IW         = $clog2(NUM_REGS)
) (
  input  logic          s_clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [IW-1:0] host_idx,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_stb,
  output logic [IW-1:0] wr_idx,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam int unsigned DEPTH = 1 << IW;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl, sda, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]             cnt;
  logic [7:0]             shreg;
  logic [IW-1:0]          ptr, ptr_inc;
  logic                   rw;
  logic [7:0]             regs [DEPTH];
  logic                   byte_done, addr_hit, ptr_ok;
  logic [7:0]             rd_byte, rx_byte;
  logic                   sda_oe_nxt, busy_nxt;

  assign scl       = scl_sync[SYNC_STAGES-1];
  assign sda       = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl && !scl_d;
  assign scl_fall  = !scl && scl_d;
  assign start_det = scl && scl_d && !sda && sda_d;
  assign stop_det  = scl && scl_d && sda && !sda_d;

  assign byte_done = (cnt == 4'd8);
  assign addr_hit  = (shreg[7:1] == ADDR);
  assign ptr_ok    = (32'(shreg) < NUM_REGS);
  assign rd_byte   = regs[ptr];
  assign rx_byte   = {shreg[6:0], sda};
  assign ptr_inc   = (ptr == IW'(NUM_REGS - 1)) ? '0 : ptr + IW'(1);

  // State register
  always_ff @(posedge s_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: START/STOP override everything; ACK slots end on the 9th SCL fall
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = S_IDLE;
    end else if (start_det) begin
      state_nxt = S_ADDR;
    end else begin
      case (state)
        S_ADDR:      if (scl_fall && byte_done) state_nxt = addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:  if (scl_fall) state_nxt = rw ? S_RDATA : S_PTR;
        S_PTR:       if (scl_fall && byte_done) state_nxt = ptr_ok ? S_PTR_ACK : S_WAIT_STOP;
        S_PTR_ACK:   if (scl_fall) state_nxt = S_WDATA;
        S_WDATA:     if (scl_fall && byte_done) state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall) state_nxt = S_WDATA;
        S_RDATA:     if (scl_fall && byte_done) state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: begin
          if (scl_rise && sda) state_nxt = S_WAIT_STOP;
          else if (scl_fall)   state_nxt = S_RDATA;
        end
        default: ;
      endcase
    end
  end

  // Next values of the registered bus outputs; SDA only moves on SCL falls
  always_comb begin
    sda_oe_nxt = sda_oe;
    busy_nxt   = busy;
    if (start_det || stop_det) begin
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (scl_fall) begin
      case (state)
        S_ADDR: if (byte_done && addr_hit) begin
          sda_oe_nxt = 1'b1;
          busy_nxt   = 1'b1;
        end
        S_ADDR_ACK:  sda_oe_nxt = rw & ~rd_byte[7];
        S_PTR:       if (byte_done) sda_oe_nxt = ptr_ok;
        S_WDATA:     if (byte_done) sda_oe_nxt = 1'b1;
        S_RDATA:     sda_oe_nxt = byte_done ? 1'b0 : ~shreg[6];
        S_RDATA_ACK: sda_oe_nxt = ~rd_byte[7];
        default:     sda_oe_nxt = 1'b0;
      endcase
    end
  end

  // Synchronisers, shift/count datapath, pointer and register bank
  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_d      <= 1'b1;
      sda_d      <= 1'b1;
      cnt        <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_stb     <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      host_rdata <= '0;
      regs       <= '{default: 8'h00};
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d      <= scl;
      sda_d      <= sda;
      sda_oe     <= sda_oe_nxt;
      busy       <= busy_nxt;
      wr_stb     <= 1'b0;
      host_rdata <= regs[host_idx];
      if (host_we) regs[host_idx] <= host_wdata;
      if (start_det) begin
        cnt <= '0;
      end else if (!stop_det) begin
        if (scl_rise) begin
          case (state)
            S_ADDR, S_PTR: begin
              shreg <= rx_byte;
              cnt   <= cnt + 4'd1;
            end
            S_WDATA: begin
              shreg <= rx_byte;
              cnt   <= cnt + 4'd1;
              // Bus write is placed after the host write so it wins a same-index collision
              if (cnt == 4'd7) begin
                regs[ptr] <= rx_byte;
                wr_stb    <= 1'b1;
                wr_idx    <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr_inc;
              end
            end
            S_RDATA:     cnt <= cnt + 4'd1;
            S_RDATA_ACK: ptr <= ptr_inc;
            default: ;
          endcase
        end else if (scl_fall) begin
          case (state)
            S_ADDR: if (byte_done) rw <= shreg[0];
            S_PTR:  if (byte_done && ptr_ok) ptr <= IW'(shreg);
            S_ADDR_ACK, S_RDATA_ACK: begin
              cnt   <= '0;
              shreg <= rd_byte;
            end
            S_PTR_ACK, S_WDATA_ACK: cnt <= '0;
            S_RDATA: if (!byte_done) shreg <= {shreg[6:0], 1'b0};
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_bank.sv
// Bench for i2c_target_bank: bit-level I2C master, directed scenarios and
// randomized transactions checked against a register-array model.
module tb_i2c_target_bank;

  localparam int         NREGS = 16;
  localparam int         IW    = 4;
  localparam logic [6:0] TADDR = 7'h34;

  logic          s_clk = 1'b0;
  logic          rst_n, m_scl, m_sda, sda_oe, host_we, wr_stb, busy;
  logic [IW-1:0] host_idx, wr_idx;
  logic [7:0]    host_wdata, host_rdata, wr_data;
  wire           sda_bus = m_sda & ~sda_oe;

  always #5 s_clk = ~s_clk;

  i2c_target_bank #(.ADDR(TADDR), .NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
    .s_clk(s_clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .host_we(host_we), .host_idx(host_idx), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data),
    .busy(busy)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_regs [NREGS];
  int          m_ptr;
  logic [7:0]  dbuf [4];
  logic [7:0]  rbuf [4];
  logic [11:0] exp_wr [$];
  logic [11:0] wr_log [$];
  int          rd_i = 0;
  int          oe_cnt = 0;
  int          busy_cnt = 0;

  // Observe bus-side register writes and activity of the drive/busy outputs
  always @(negedge s_clk) begin
    if (wr_stb) wr_log.push_back({wr_idx, wr_data});
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge s_clk);
  endtask

  // One SCL clock: data set mid-low, sampled mid-high; SCL left low
  task automatic bit_out(input logic b, output logic smp);
    tick(3); m_sda = b;
    tick(5); m_scl = 1'b1;
    tick(4); smp = sda_bus;
    tick(4); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; tick(8); m_scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    tick(3); m_sda = 1'b1;
    tick(5); m_scl = 1'b1;
    tick(8); m_sda = 1'b0;
    tick(8); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(3); m_sda = 1'b0;
    tick(5); m_scl = 1'b1;
    tick(8); m_sda = 1'b1;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(v[i], s);
    bit_out(1'b1, ack);
  endtask

  task automatic read_byte(input logic last, output logic [7:0] d);
    logic s;
    for (int i = 0; i < 8; i++) begin
      bit_out(1'b1, s);
      d = {d[6:0], s};
    end
    bit_out(last, s);
  endtask

  task automatic host_write(input int idx, input logic [7:0] v);
    host_we = 1'b1; host_idx = IW'(idx); host_wdata = v;
    tick(1);
    host_we = 1'b0;
    m_regs[idx] = v;
  endtask

  task automatic host_read_check(input string tag, input int idx, input logic [7:0] exp);
    host_idx = IW'(idx);
    tick(1);
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = wr_log.size() - rd_i;
    check({tag, "_wr_count"}, 32'(n), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < n; i++)
      check({tag, "_wr"}, 32'(wr_log[rd_i + i]), 32'(exp_wr[i]));
    rd_i = wr_log.size();
    exp_wr.delete();
  endtask

  // Write transaction: address byte, pointer byte, n data bytes from dbuf
  task automatic wr_txn(input string tag, input logic [7:0] abyte, input logic [7:0] p, input int n);
    logic ack, hit, pok;
    int   oe0, busy0;
    hit   = (abyte[7:1] == TADDR) && !abyte[0];
    pok   = hit && (int'(p) < NREGS);
    oe0   = oe_cnt;
    busy0 = busy_cnt;
    i2c_start();
    send_byte(abyte, ack);
    check({tag, "_addr_ack"}, 32'(ack), 32'(!hit));
    check({tag, "_busy_hi"}, 32'(busy), 32'(hit));
    if (hit) begin
      send_byte(p, ack);
      check({tag, "_ptr_ack"}, 32'(ack), 32'(!pok));
      if (pok) m_ptr = int'(p);
      for (int i = 0; i < n; i++) begin
        send_byte(dbuf[i], ack);
        check({tag, "_data_ack"}, 32'(ack), 32'(!pok));
        if (pok) begin
          m_regs[m_ptr] = dbuf[i];
          exp_wr.push_back({IW'(m_ptr), dbuf[i]});
          m_ptr = (m_ptr + 1) % NREGS;
        end
      end
    end
    i2c_stop();
    tick(4);
    check({tag, "_busy_lo"}, 32'(busy), 32'(0));
    if (!hit) begin
      check({tag, "_oe_quiet"}, 32'(oe_cnt - oe0), 32'(0));
      check({tag, "_busy_quiet"}, 32'(busy_cnt - busy0), 32'(0));
    end
    check_writes(tag);
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START
  task automatic rd_txn(input string tag, input logic with_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    if (with_ptr) begin
      send_byte({TADDR, 1'b0}, ack);
      check({tag, "_addrw_ack"}, 32'(ack), 32'(0));
      send_byte(p, ack);
      check({tag, "_ptr_ack"}, 32'(ack), 32'(int'(p) >= NREGS));
      if (int'(p) < NREGS) m_ptr = int'(p);
      i2c_rstart();
    end
    send_byte({TADDR, 1'b1}, ack);
    check({tag, "_addrr_ack"}, 32'(ack), 32'(0));
    check({tag, "_busy_hi"}, 32'(busy), 32'(1));
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rbuf[i] = d;
      check({tag, "_rdata"}, 32'(d), 32'(m_regs[m_ptr]));
      m_ptr = (m_ptr + 1) % NREGS;
    end
    i2c_stop();
    tick(4);
    check({tag, "_busy_lo"}, 32'(busy), 32'(0));
    check_writes(tag);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] v;
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    host_we = 1'b0; host_idx = '0; host_wdata = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    tick(5);
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_wr_stb", 32'(wr_stb), 32'(0));
    check("rst_host_rdata", 32'(host_rdata), 32'(0));
    rst_n = 1'b1;
    tick(4);

    // Single write to register 5
    dbuf[0] = 8'hAA;
    wr_txn("w5", 8'h68, 8'h05, 1);
    host_read_check("w5_host", 5, 8'hAA);

    // Write wrapping from the last register to register 0
    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    wr_txn("wrap", 8'h68, 8'h0F, 2);
    host_read_check("wrap_r15", 15, 8'h11);
    host_read_check("wrap_r0", 0, 8'h22);
    rd_txn("wrap_ptr", 1'b0, 8'h00, 1);

    // Host-written data read back over the bus through a repeated START
    host_write(3, 8'h5C);
    host_write(4, 8'hC3);
    rd_txn("rd34", 1'b1, 8'h03, 2);
    check("rd34_b0", 32'(rbuf[0]), 32'(8'h5C));
    check("rd34_b1", 32'(rbuf[1]), 32'(8'hC3));

    // Foreign address and out-of-range pointer
    wr_txn("noaddr", 8'h6A, 8'h00, 0);
    dbuf[0] = 8'h33; dbuf[1] = 8'h44;
    wr_txn("badptr", 8'h68, 8'h20, 2);

    // Randomized mix of writes, pointer reads, continuing reads and host writes
    for (int t = 0; t < 20; t++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) host_write(int'($urandom_range(0, NREGS - 1)), 8'($urandom));
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
      case (kind)
        0, 1:    wr_txn("rnd_w", 8'h68, 8'($urandom_range(0, 19)), int'($urandom_range(1, 3)));
        2:       rd_txn("rnd_rp", 1'b1, 8'($urandom_range(0, 17)), int'($urandom_range(1, 3)));
        default: rd_txn("rnd_rc", 1'b0, 8'h00, int'($urandom_range(1, 3)));
      endcase
    end
    for (int i = 0; i < NREGS; i++) host_read_check("sweep", i, m_regs[i]);

    // Reset asserted during the ACK slot of a data byte
    i2c_start();
    send_byte(8'h68, ack);
    check("rstack_addr_ack", 32'(ack), 32'(0));
    send_byte(8'h05, ack);
    check("rstack_ptr_ack", 32'(ack), 32'(0));
    v = 8'hAA;
    for (int i = 7; i >= 0; i--) bit_out(v[i], s);
    tick(4);
    check("rstack_oe_before", 32'(sda_oe), 32'(1));
    rst_n = 1'b0;
    tick(1);
    check("rstack_oe_reset", 32'(sda_oe), 32'(0));
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    rd_i = wr_log.size();
    exp_wr.delete();
    for (int i = 0; i < NREGS; i++) host_read_check("rstack_clear", i, 8'h00);
    i2c_stop();
    dbuf[0] = 8'hAA;
    wr_txn("post_rst", 8'h68, 8'h05, 1);
    host_read_check("post_rst_host", 5, 8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
